// File: rtl/ro_gray_scheduler.sv
// Gray-code readout scheduler: each advance serves the channel whose gray bit toggles (channel k every 2^(k+1) cycles).
// Events wait in per-channel pending flags until their slot. All outputs are registered with one cycle latency, and there is no backpressure.
module ro_gray_scheduler #(
  parameter int N_CH = 8,
  parameter int IW   = $clog2(N_CH)
) (
  input  logic            clk_master,
  input  logic            rstb,
  input  logic            en,
  input  logic [N_CH-1:0] ch_mask,
  input  logic [N_CH-1:0] in_eve,
  input  logic [N_CH-1:0] in_pol_eve,
  input  logic            clr_overrun,
  output logic [N_CH-1:0] gray_o,
  output logic [N_CH-1:0] grant_o,
  output logic            slot_valid_o,
  output logic [IW-1:0]   slot_ch_o,
  output logic            out_eve_o,
  output logic            out_pol_eve_o,
  output logic            frame_o,
  output logic [N_CH-1:0] overrun_o
);

  localparam logic [N_CH-1:0] ONE = {{(N_CH-1){1'b0}}, 1'b1};

  logic [N_CH-1:0] b;
  logic [N_CH-1:0] b_inc;
  logic [N_CH-1:0] pend_eve;
  logic [N_CH-1:0] pend_pol;
  logic [N_CH-1:0] sel;
  logic [N_CH-1:0] serve_vec;
  logic [N_CH-1:0] ovr_set;
  logic [IW-1:0]   t;
  logic            t_found;
  logic            serve;

  assign b_inc = b + ONE;

  // Lowest zero bit of b is the gray bit that flips on this advance; all-ones wraps on the MSB.
  always_comb begin
    t       = IW'(N_CH - 1);
    t_found = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (!t_found && !b[i]) begin
        t       = IW'(i);
        t_found = 1'b1;
      end
    end
  end

  assign serve     = en & ch_mask[t];
  assign sel       = ONE << t;
  assign serve_vec = serve ? sel : '0;
  // The served channel's own event bypasses straight to the output, so it can never overrun.
  assign ovr_set   = in_eve & pend_eve & ~serve_vec;

  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      b             <= '0;
      gray_o        <= '0;
      grant_o       <= '0;
      slot_valid_o  <= 1'b0;
      slot_ch_o     <= '0;
      out_eve_o     <= 1'b0;
      out_pol_eve_o <= 1'b0;
      frame_o       <= 1'b0;
      pend_eve      <= '0;
      pend_pol      <= '0;
      overrun_o     <= '0;
    end else begin
      if (en) begin
        b       <= b_inc;
        gray_o  <= b_inc ^ (b_inc >> 1);
        frame_o <= &b;
      end else begin
        frame_o <= 1'b0;
      end

      if (serve) begin
        grant_o       <= sel;
        slot_valid_o  <= 1'b1;
        slot_ch_o     <= t;
        out_eve_o     <= pend_eve[t] | in_eve[t];
        out_pol_eve_o <= pend_pol[t] | (in_eve[t] & in_pol_eve[t]);
      end else begin
        grant_o       <= '0;
        slot_valid_o  <= 1'b0;
        slot_ch_o     <= '0;
        out_eve_o     <= 1'b0;
        out_pol_eve_o <= 1'b0;
      end

      pend_eve  <= (pend_eve | in_eve) & ~serve_vec;
      pend_pol  <= (pend_pol | (in_eve & in_pol_eve)) & ~serve_vec;
      overrun_o <= (overrun_o & ~{N_CH{clr_overrun}}) | ovr_set;
    end
  end

endmodule

// File: tb/tb_ro_gray_scheduler.sv
// Bench for ro_gray_scheduler: directed scenarios plus random traffic against a slot-level model.
module tb_ro_gray_scheduler;
  localparam int N = 8;

  logic         clk;
  logic         rstb;
  logic         en;
  logic [N-1:0] ch_mask;
  logic [N-1:0] in_eve;
  logic [N-1:0] in_pol_eve;
  logic         clr_overrun;
  logic [N-1:0] gray;
  logic [N-1:0] grant;
  logic         slot_valid;
  logic [2:0]   slot_ch;
  logic         out_eve;
  logic         out_pol;
  logic         frame;
  logic [N-1:0] overrun;

  logic         en3;
  logic [2:0]   mask3;
  logic [2:0]   gray3;
  logic [2:0]   grant3;
  logic         valid3;
  logic [1:0]   ch3;
  logic         eve3;
  logic         pol3;
  logic         frame3;
  logic [2:0]   ovr3;

  int n_checks = 0;
  int n_err    = 0;

  int           cnt;
  logic [N-1:0] m_pe;
  logic [N-1:0] m_pp;
  logic [N-1:0] m_ov;
  logic [N-1:0] e_gray;
  logic [N-1:0] e_grant;
  logic         e_valid;
  logic [2:0]   e_ch;
  logic         e_eve;
  logic         e_pol;
  logic         e_frame;

  ro_gray_scheduler #(.N_CH(N)) u_dut (
    .clk_master(clk), .rstb(rstb), .en(en), .ch_mask(ch_mask),
    .in_eve(in_eve), .in_pol_eve(in_pol_eve), .clr_overrun(clr_overrun),
    .gray_o(gray), .grant_o(grant), .slot_valid_o(slot_valid), .slot_ch_o(slot_ch),
    .out_eve_o(out_eve), .out_pol_eve_o(out_pol), .frame_o(frame), .overrun_o(overrun)
  );

  ro_gray_scheduler #(.N_CH(3)) u_dut3 (
    .clk_master(clk), .rstb(rstb), .en(en3), .ch_mask(mask3),
    .in_eve(3'b000), .in_pol_eve(3'b000), .clr_overrun(1'b0),
    .gray_o(gray3), .grant_o(grant3), .slot_valid_o(valid3), .slot_ch_o(ch3),
    .out_eve_o(eve3), .out_pol_eve_o(pol3), .frame_o(frame3), .overrun_o(ovr3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    cnt = 0; m_pe = '0; m_pp = '0; m_ov = '0;
    e_gray = '0; e_grant = '0; e_valid = 1'b0; e_ch = '0;
    e_eve = 1'b0; e_pol = 1'b0; e_frame = 1'b0;
  endtask

  // Served channel = the gray bit that differs between old and new count.
  task automatic model_step();
    int g_old, g_new, nb, diff, t;
    logic [N-1:0] sv;
    sv = '0; t = 0;
    e_grant = '0; e_valid = 1'b0; e_ch = '0; e_eve = 1'b0; e_pol = 1'b0; e_frame = 1'b0;
    if (en) begin
      nb    = (cnt + 1) % (1 << N);
      g_old = cnt ^ (cnt >> 1);
      g_new = nb ^ (nb >> 1);
      diff  = g_old ^ g_new;
      for (int k = 0; k < N; k++) if (diff[k]) t = k;
      e_frame = (cnt == (1 << N) - 1);
      if (ch_mask[t]) begin
        sv[t]   = 1'b1;
        e_grant = N'(1 << t);
        e_valid = 1'b1;
        e_ch    = 3'(t);
        e_eve   = m_pe[t] | in_eve[t];
        e_pol   = m_pp[t] | (in_eve[t] & in_pol_eve[t]);
      end
      cnt = nb;
    end
    e_gray = N'(cnt ^ (cnt >> 1));
    if (clr_overrun) m_ov = '0;
    for (int k = 0; k < N; k++) begin
      if (sv[k]) begin
        m_pe[k] = 1'b0;
        m_pp[k] = 1'b0;
      end else if (in_eve[k]) begin
        if (m_pe[k]) m_ov[k] = 1'b1;
        m_pe[k] = 1'b1;
        if (in_pol_eve[k]) m_pp[k] = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    check("gray", 32'(gray), 32'(e_gray));
    check("grant", 32'(grant), 32'(e_grant));
    check("slot_valid", 32'(slot_valid), 32'(e_valid));
    check("slot_ch", 32'(slot_ch), 32'(e_ch));
    check("out_eve", 32'(out_eve), 32'(e_eve));
    check("out_pol", 32'(out_pol), 32'(e_pol));
    check("frame", 32'(frame), 32'(e_frame));
    check("overrun", 32'(overrun), 32'(m_ov));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic quiet();
    in_eve = '0; in_pol_eve = '0; clr_overrun = 1'b0;
  endtask

  task automatic do_reset();
    rstb = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    rstb = 1'b1;
    quiet();
    en = 1'b1;
    ch_mask = '1;
  endtask

  int exp_ch3[8]   = '{0, 1, 0, 2, 0, 1, 0, 2};
  int exp_gray3[8] = '{1, 3, 2, 6, 7, 5, 4, 0};
  int exp_seq8[8]  = '{0, 1, 0, 2, 0, 1, 0, 3};

  initial begin
    rstb = 1'b0; en = 1'b0; ch_mask = '0; en3 = 1'b0; mask3 = '0;
    quiet();
    model_reset();
    // Reset held with inputs toggling: everything stays zero.
    for (int i = 0; i < 4; i++) begin
      en = 1'($urandom); ch_mask = N'($urandom); in_eve = N'($urandom);
      in_pol_eve = N'($urandom); clr_overrun = 1'($urandom);
      en3 = 1'($urandom); mask3 = 3'($urandom);
      @(posedge clk);
      #1;
      compare_all();
      check("rst_gray3", 32'(gray3), 32'd0);
      check("rst_valid3", 32'(valid3), 32'd0);
    end
    rstb = 1'b1;
    quiet();
    en = 1'b0;

    // Three-channel wrap.
    en3 = 1'b1; mask3 = 3'b111;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check("wrap_ch3", 32'(ch3), 32'(exp_ch3[i]));
      check("wrap_gray3", 32'(gray3), 32'(exp_gray3[i]));
      check("wrap_grant3", 32'(grant3), 32'(1 << exp_ch3[i]));
      check("wrap_frame3", 32'(frame3), (i == 7) ? 32'd1 : 32'd0);
    end
    en3 = 1'b0;

    // Slot order after reset release.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step();
      check("seq_ch", 32'(slot_ch), 32'(exp_seq8[i]));
      check("seq_onehot", 32'($countones(grant)), 32'd1);
    end

    // Buffering: event at b=0 on channel 2, delivered on the 3->4 advance.
    do_reset();
    in_eve = 8'h04; in_pol_eve = 8'h04;
    step();
    quiet();
    for (int i = 0; i < 3; i++) step();
    check("buf_ch", 32'(slot_ch), 32'd2);
    check("buf_eve", 32'(out_eve), 32'd1);
    check("buf_pol", 32'(out_pol), 32'd1);
    for (int i = 0; i < 8; i++) step();
    check("buf_next_ch", 32'(slot_ch), 32'd2);
    check("buf_next_eve", 32'(out_eve), 32'd0);

    // Overrun on channel 1, sticky, cleared, then no overrun on the slot edge.
    do_reset();
    step(); step();
    in_eve = 8'h02; step();
    in_eve = 8'h02; step();
    quiet();
    check("ovr_set", 32'(overrun[1]), 32'd1);
    step();
    check("ovr_sticky", 32'(overrun[1]), 32'd1);
    en = 1'b0; clr_overrun = 1'b1; step();
    clr_overrun = 1'b0;
    check("ovr_clr", 32'(overrun[1]), 32'd0);
    en = 1'b1; in_eve = 8'h02; step();
    quiet();
    check("ovr_slot_ch", 32'(slot_ch), 32'd1);
    check("ovr_slot_eve", 32'(out_eve), 32'd1);
    check("ovr_bypass", 32'(overrun[1]), 32'd0);

    // Mask channel 0, then restore; then idle.
    do_reset();
    ch_mask = 8'hFE; in_eve = 8'h01; in_pol_eve = 8'h01; step();
    quiet();
    check("mask_valid0", 32'(slot_valid), 32'd0);
    step(); step();
    check("mask_valid2", 32'(slot_valid), 32'd0);
    ch_mask = '1; step(); step();
    check("mask_ch", 32'(slot_ch), 32'd0);
    check("mask_eve", 32'(out_eve), 32'd1);
    check("mask_pol", 32'(out_pol), 32'd1);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle_gray", 32'(gray), 32'd7);
      check("idle_valid", 32'(slot_valid), 32'd0);
    end

    // Random traffic with an asynchronous reset in the middle.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      en          = ($urandom_range(9) != 0);
      ch_mask     = ($urandom_range(3) == 0) ? N'($urandom) : '1;
      in_eve      = N'($urandom & $urandom & $urandom);
      in_pol_eve  = N'($urandom);
      clr_overrun = ($urandom_range(15) == 0);
      step();
      if (i == 800) begin
        #2;
        rstb = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        rstb = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
